// File: rtl/noc_vc_injection_arbiter.sv
// -----------------------------------------------------------------------------
// noc_vc_injection_arbiter
//
// Purpose:
//   Shares one NoC injection port among NumberOfRequesters valid/ready flit
//   sources. Each source tags its flits with a virtual channel id. In IDLE the
//   block picks a winner round-robin among sources whose target VC is
//   available. A multi-flit packet then locks the port to its owner until the
//   owner's tail flit transfers. The block drives the router's one-hot per-VC
//   valid and the select (grant_id_o) for an external flit datapath mux.
//
// Handshake:
//   Upstream, a flit moves from source r when valid_i[r] && ready_o[r] in the
//   same cycle. Sources hold valid_i, virtual_channel_id_i and tail_i stable
//   until that happens. Downstream, valid_o is one-hot on the VC of the moving
//   flit and is only raised while avail_i of that VC is high. grant_valid_o
//   marks the transfer cycle. All paths from valid_i/avail_i to
//   ready_o/valid_o are combinational, so there is zero added latency.
//
// Ports:
//   clk_i                 clock
//   rst_ni                synchronous active-low reset
//   valid_i   [N]         per-source flit valid
//   ready_o   [N]         per-source ready
//   virtual_channel_id_i  per-source target VC, slice r belongs to source r
//   tail_i    [N]         per-source last-flit-of-packet marker
//   grant_id_o            source whose flit is on the datapath (holds when idle)
//   grant_valid_o         a transfer happens this cycle
//   valid_o   [V]         one-hot NoC valid for the transferred flit's VC
//   avail_i   [V]         NoC per-VC availability this cycle
//   error_o               sticky protocol error (illegal VC id, or VC change
//                         inside a locked packet)
//
// Optional build macro NOC_VC_INJECTION_ARBITER_STATS_EN adds saturating
// 32-bit counters flit_count_o, packet_count_o and stall_count_o.
// -----------------------------------------------------------------------------
module noc_vc_injection_arbiter #(
  parameter int NumberOfRequesters      = 4,
  parameter int RequesterIdWidth        = 2,
  parameter int NumberOfVirtualChannels = 3,
  parameter int VirtualChannelIdWidth   = 2
) (
  input  logic                                                clk_i,
  input  logic                                                rst_ni,
  input  logic [NumberOfRequesters-1:0]                       valid_i,
  output logic [NumberOfRequesters-1:0]                       ready_o,
  input  logic [NumberOfRequesters*VirtualChannelIdWidth-1:0] virtual_channel_id_i,
  input  logic [NumberOfRequesters-1:0]                       tail_i,
  output logic [RequesterIdWidth-1:0]                         grant_id_o,
  output logic                                                grant_valid_o,
  output logic [NumberOfVirtualChannels-1:0]                  valid_o,
  input  logic [NumberOfVirtualChannels-1:0]                  avail_i,
  output logic                                                error_o
`ifdef NOC_VC_INJECTION_ARBITER_STATS_EN
  ,
  output logic [31:0]                                         flit_count_o,
  output logic [31:0]                                         packet_count_o,
  output logic [31:0]                                         stall_count_o
`endif
);

  localparam int N   = NumberOfRequesters;
  localparam int RIW = RequesterIdWidth;
  localparam int NVC = NumberOfVirtualChannels;
  localparam int VCW = VirtualChannelIdWidth;

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } state_e;

  state_e         state_q, state_d;
  logic [RIW-1:0] rr_ptr_q, rr_ptr_d;
  logic [RIW-1:0] owner_q, owner_d;
  logic [VCW-1:0] locked_vc_q, locked_vc_d;
  logic           error_q, error_d;
  logic [RIW-1:0] grant_id_q, grant_id_d;

  logic [N-1:0]   eligible;
  logic           vc_bad;
  logic           found;
  logic [RIW-1:0] winner;
  logic [VCW-1:0] vc_win;
  logic [VCW-1:0] vc_owner;
  logic           owner_avail;
  int             idx;

  function automatic logic [RIW-1:0] inc_wrap(input logic [RIW-1:0] x);
    if (int'(x) == N - 1) return '0;
    return x + RIW'(1);
  endfunction

  function automatic logic [NVC-1:0] vc_onehot(input logic [VCW-1:0] vc);
    logic [NVC-1:0] oh;
    oh = '0;
    for (int v = 0; v < NVC; v++) oh[v] = (int'(vc) == v);
    return oh;
  endfunction

  always_comb begin
    state_d       = state_q;
    rr_ptr_d      = rr_ptr_q;
    owner_d       = owner_q;
    locked_vc_d   = locked_vc_q;
    error_d       = error_q;
    ready_o       = '0;
    valid_o       = '0;
    grant_valid_o = 1'b0;
    grant_id_o    = grant_id_q;
    eligible      = '0;
    vc_bad        = 1'b0;
    found         = 1'b0;
    winner        = '0;
    vc_win        = '0;
    vc_owner      = '0;
    owner_avail   = 1'b0;
    idx           = 0;

    // An out-of-range VC id is never eligible, so indexing avail_i with it
    // is guarded; a valid source presenting one is a protocol error.
    for (int r = 0; r < N; r++) begin
      if (int'(virtual_channel_id_i[r*VCW +: VCW]) < NVC) begin
        eligible[r] = valid_i[r] && avail_i[virtual_channel_id_i[r*VCW +: VCW]];
      end else if (valid_i[r]) begin
        vc_bad = 1'b1;
      end
    end

    // Scan from rr_ptr upward with wrap; first eligible source wins.
    for (int i = 0; i < N; i++) begin
      idx = (int'(rr_ptr_q) + i) % N;
      if (!found && eligible[idx]) begin
        found  = 1'b1;
        winner = RIW'(idx);
      end
    end
    vc_win = virtual_channel_id_i[int'(winner)*VCW +: VCW];

    vc_owner    = virtual_channel_id_i[int'(owner_q)*VCW +: VCW];
    // locked_vc_q only ever holds a VC that was eligible, so it is in range.
    owner_avail = avail_i[locked_vc_q];

    if (vc_bad) error_d = 1'b1;

    case (state_q)
      IDLE: begin
        if (found) begin
          ready_o[winner] = 1'b1;
          grant_valid_o   = 1'b1;
          grant_id_o      = winner;
          valid_o         = vc_onehot(vc_win);
          if (tail_i[winner]) begin
            rr_ptr_d = inc_wrap(winner);
          end else begin
            state_d     = LOCKED;
            owner_d     = winner;
            locked_vc_d = vc_win;
          end
        end
      end
      LOCKED: begin
        ready_o[owner_q] = owner_avail;
        // A VC change mid-packet is flagged but the flit still goes out on
        // the locked VC.
        if (valid_i[owner_q] && (vc_owner != locked_vc_q)) error_d = 1'b1;
        if (valid_i[owner_q] && owner_avail) begin
          grant_valid_o = 1'b1;
          grant_id_o    = owner_q;
          valid_o       = vc_onehot(locked_vc_q);
          if (tail_i[owner_q]) begin
            state_d  = IDLE;
            rr_ptr_d = inc_wrap(owner_q);
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // In reset every combinational output is quiet so nothing transfers.
    if (!rst_ni) begin
      ready_o       = '0;
      valid_o       = '0;
      grant_valid_o = 1'b0;
      grant_id_o    = '0;
    end
    grant_id_d = grant_id_o;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q     <= IDLE;
      rr_ptr_q    <= '0;
      owner_q     <= '0;
      locked_vc_q <= '0;
      error_q     <= 1'b0;
      grant_id_q  <= '0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      owner_q     <= owner_d;
      locked_vc_q <= locked_vc_d;
      error_q     <= error_d;
      grant_id_q  <= grant_id_d;
    end
  end

  assign error_o = error_q;

`ifdef NOC_VC_INJECTION_ARBITER_STATS_EN
  logic [31:0] flit_count_q, flit_count_d;
  logic [31:0] packet_count_q, packet_count_d;
  logic [31:0] stall_count_q, stall_count_d;

  always_comb begin
    flit_count_d   = flit_count_q;
    packet_count_d = packet_count_q;
    stall_count_d  = stall_count_q;
    if (grant_valid_o && (flit_count_q != '1)) flit_count_d = flit_count_q + 32'd1;
    if (grant_valid_o && tail_i[grant_id_o] && (packet_count_q != '1))
      packet_count_d = packet_count_q + 32'd1;
    if ((state_q == LOCKED) && valid_i[owner_q] && !owner_avail && (stall_count_q != '1))
      stall_count_d = stall_count_q + 32'd1;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      flit_count_q   <= '0;
      packet_count_q <= '0;
      stall_count_q  <= '0;
    end else begin
      flit_count_q   <= flit_count_d;
      packet_count_q <= packet_count_d;
      stall_count_q  <= stall_count_d;
    end
  end

  assign flit_count_o   = flit_count_q;
  assign packet_count_o = packet_count_q;
  assign stall_count_o  = stall_count_q;
`endif

endmodule

// File: tb/tb_noc_vc_injection_arbiter.sv
// -----------------------------------------------------------------------------
// Testbench for noc_vc_injection_arbiter (default parameters: 4 sources,
// 3 VCs). Inputs change 1 time unit after the rising edge; outputs are
// sampled on the falling edge. Each expected transfer {grant_id, valid_o} is
// pushed to exp_q when its stimulus is driven; the scoreboard process pops
// and compares whenever the DUT reports grant_valid_o.
// -----------------------------------------------------------------------------
module tb_noc_vc_injection_arbiter;
  localparam int N   = 4;
  localparam int RIW = 2;
  localparam int NVC = 3;
  localparam int VCW = 2;
  localparam int W   = RIW + NVC;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [N-1:0]     valid;
  logic [N-1:0]     ready;
  logic [N-1:0]     tail;
  logic [VCW-1:0]   vc_s [N];
  logic [N*VCW-1:0] vc_bus;
  logic [RIW-1:0]   gid;
  logic             gvalid;
  logic [NVC-1:0]   vout;
  logic [NVC-1:0]   avail;
  logic             err;
`ifdef NOC_VC_INJECTION_ARBITER_STATS_EN
  logic [31:0]      flit_cnt, pkt_cnt, stall_cnt;
`endif

  int n_cmp = 0;
  int n_err = 0;
  bit sb_on = 1'b0;
  logic [W-1:0] exp_q[$];

  assign vc_bus = {vc_s[3], vc_s[2], vc_s[1], vc_s[0]};

  always #5 clk = ~clk;

  noc_vc_injection_arbiter dut (
    .clk_i                (clk),
    .rst_ni               (rst_n),
    .valid_i              (valid),
    .ready_o              (ready),
    .virtual_channel_id_i (vc_bus),
    .tail_i               (tail),
    .grant_id_o           (gid),
    .grant_valid_o        (gvalid),
    .valid_o              (vout),
    .avail_i              (avail),
    .error_o              (err)
`ifdef NOC_VC_INJECTION_ARBITER_STATS_EN
    ,
    .flit_count_o         (flit_cnt),
    .packet_count_o       (pkt_cnt),
    .stall_count_o        (stall_cnt)
`endif
  );

  function automatic logic [NVC-1:0] oh_vc(input int v);
    logic [NVC-1:0] one;
    one = 1;
    return one << v;
  endfunction

  function automatic logic [N-1:0] oh_src(input int s);
    logic [N-1:0] one;
    one = 1;
    return one << s;
  endfunction

  // Scoreboard plus per-cycle output invariants.
  always @(negedge clk) begin : scoreboard
    logic [W-1:0] exp_v;
    if (sb_on && rst_n) begin
      n_cmp++;
      if ($countones(vout) > 1 || $countones(ready) > 1 || ((vout != 0) != gvalid)) begin
        n_err++;
        $display("FAIL invariant: ready=%b valid_o=%b grant_valid=%b", ready, vout, gvalid);
      end
      if (gvalid) begin
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_err++;
          $display("FAIL unexpected_grant: got id=%0d valid_o=%b, required no transfer", gid, vout);
        end else begin
          exp_v = exp_q.pop_front();
          if ({gid, vout} !== exp_v) begin
            n_err++;
            $display("FAIL grant: got id=%0d valid_o=%b, required id=%0d valid_o=%b",
                     gid, vout, exp_v[W-1:NVC], exp_v[NVC-1:0]);
          end
        end
      end
    end
  end

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    valid = '0;
    tail  = '0;
    for (int s = 0; s < N; s++) vc_s[s] = '0;
    avail = '1;
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    idle_inputs();
    cycle();
    rst_n = 1'b1;
  endtask

  task automatic check_drained(input string name);
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL %s_drain: %0d expected transfers never seen, required 0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    valid = '1;
    tail  = '1;
    avail = 3'b111;
    for (int s = 0; s < N; s++) vc_s[s] = '0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      n_cmp++;
      if ({ready, vout, gvalid, gid, err} !== '0) begin
        n_err++;
        $display("FAIL reset_outputs: ready=%b valid_o=%b gv=%b id=%0d err=%b, required all 0",
                 ready, vout, gvalid, gid, err);
      end
      cycle();
    end
    rst_n = 1'b1;
    exp_q.push_back({2'd0, 3'b001});
    @(negedge clk);
    n_cmp++;
    if (ready !== 4'b0001) begin
      n_err++;
      $display("FAIL reset_first_ready: got %b, required 0001", ready);
    end
    cycle();
    valid = '0;
    check_drained("reset");
  endtask

  task automatic test_round_robin();
    apply_reset();
    valid = '1;
    tail  = '1;
    avail = 3'b001;
    for (int k = 0; k < 5; k++) begin
      exp_q.push_back({RIW'(k % N), 3'b001});
      @(negedge clk);
      n_cmp++;
      if (ready !== oh_src(k % N)) begin
        n_err++;
        $display("FAIL rr_ready[%0d]: got %b, required %b", k, ready, oh_src(k % N));
      end
      cycle();
    end
    valid = '0;
    check_drained("round_robin");
  endtask

  task automatic test_lock();
    apply_reset();
    avail   = 3'b111;
    vc_s[1] = 2'd2;
    vc_s[2] = 2'd0;
    tail[2] = 1'b1;
    valid   = 4'b0110;
    for (int k = 0; k < 4; k++) begin
      tail[1] = (k == 3);
      exp_q.push_back({2'd1, 3'b100});
      @(negedge clk);
      n_cmp++;
      if (ready !== 4'b0010) begin
        n_err++;
        $display("FAIL lock_ready[%0d]: got %b, required 0010", k, ready);
      end
      cycle();
    end
    valid[1] = 1'b0;
    exp_q.push_back({2'd2, 3'b001});
    @(negedge clk);
    n_cmp++;
    if (ready !== 4'b0100) begin
      n_err++;
      $display("FAIL lock_next_ready: got %b, required 0100", ready);
    end
    cycle();
    valid = '0;
    check_drained("lock");
  endtask

  task automatic test_avail_stall();
    apply_reset();
    vc_s[0] = 2'd0;
    vc_s[1] = 2'd1;
    tail    = '0;
    valid   = 4'b0011;
    avail   = 3'b010;
    exp_q.push_back({2'd1, 3'b010});
    @(negedge clk);
    n_cmp++;
    if (ready !== 4'b0010) begin
      n_err++;
      $display("FAIL skip_ready: got %b, required 0010", ready);
    end
    cycle();
    avail = 3'b000;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      n_cmp++;
      if ({gvalid, ready, gid} !== {1'b0, 4'b0000, 2'd1}) begin
        n_err++;
        $display("FAIL stall[%0d]: gv=%b ready=%b id=%0d, required gv=0 ready=0000 id=1",
                 k, gvalid, ready, gid);
      end
      cycle();
    end
    avail   = 3'b010;
    tail[1] = 1'b1;
    exp_q.push_back({2'd1, 3'b010});
    @(negedge clk);
    cycle();
    valid[1] = 1'b0;
`ifdef NOC_VC_INJECTION_ARBITER_STATS_EN
    n_cmp++;
    if ({stall_cnt, flit_cnt, pkt_cnt} !== {32'd3, 32'd2, 32'd1}) begin
      n_err++;
      $display("FAIL stats: stall=%0d flit=%0d packet=%0d, required 3 2 1", stall_cnt, flit_cnt, pkt_cnt);
    end
`endif
    // Source 0 finally gets its VC; rr_ptr is 2, so the scan wraps to it.
    avail   = 3'b001;
    tail[0] = 1'b1;
    exp_q.push_back({2'd0, 3'b001});
    @(negedge clk);
    n_cmp++;
    if (ready !== 4'b0001) begin
      n_err++;
      $display("FAIL wrap_ready: got %b, required 0001", ready);
    end
    cycle();
    valid = '0;
    check_drained("avail_stall");
  endtask

  task automatic test_vc_mismatch();
    apply_reset();
    avail   = 3'b111;
    vc_s[3] = 2'd1;
    tail    = '0;
    valid   = 4'b1000;
    exp_q.push_back({2'd3, 3'b010});
    @(negedge clk);
    n_cmp++;
    if (err !== 1'b0) begin
      n_err++;
      $display("FAIL mismatch_err_before: got %b, required 0", err);
    end
    cycle();
    vc_s[3] = 2'd2;
    exp_q.push_back({2'd3, 3'b010});
    @(negedge clk);
    n_cmp++;
    if ({err, ready} !== {1'b0, 4'b1000}) begin
      n_err++;
      $display("FAIL mismatch_cycle: err=%b ready=%b, required err=0 ready=1000", err, ready);
    end
    cycle();
    vc_s[3] = 2'd1;
    tail[3] = 1'b1;
    exp_q.push_back({2'd3, 3'b010});
    @(negedge clk);
    n_cmp++;
    if (err !== 1'b1) begin
      n_err++;
      $display("FAIL mismatch_err_after: got %b, required 1", err);
    end
    cycle();
    valid = '0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      n_cmp++;
      if (err !== 1'b1) begin
        n_err++;
        $display("FAIL err_sticky[%0d]: got %b, required 1", k, err);
      end
      cycle();
    end
    check_drained("vc_mismatch");
  endtask

  // Runs straight after test_vc_mismatch: state IDLE, rr_ptr 0, error set.
  task automatic test_reset_mid();
    avail   = 3'b111;
    vc_s[2] = 2'd0;
    tail    = '0;
    valid   = 4'b0100;
    for (int k = 0; k < 2; k++) begin
      exp_q.push_back({2'd2, 3'b001});
      @(negedge clk);
      cycle();
    end
    rst_n    = 1'b0;
    vc_s[0]  = 2'd1;
    tail[0]  = 1'b1;
    valid[0] = 1'b1;
    @(negedge clk);
    n_cmp++;
    if ({ready, vout, gvalid, gid} !== '0) begin
      n_err++;
      $display("FAIL midreset_outputs: ready=%b valid_o=%b gv=%b id=%0d, required all 0",
               ready, vout, gvalid, gid);
    end
    cycle();
    rst_n = 1'b1;
    exp_q.push_back({2'd0, 3'b010});
    @(negedge clk);
    n_cmp++;
    if ({err, ready} !== {1'b0, 4'b0001}) begin
      n_err++;
      $display("FAIL midreset_after: err=%b ready=%b, required err=0 ready=0001", err, ready);
    end
    cycle();
    valid = '0;
`ifdef NOC_VC_INJECTION_ARBITER_STATS_EN
    n_cmp++;
    if ({flit_cnt, pkt_cnt, stall_cnt} !== {32'd1, 32'd1, 32'd0}) begin
      n_err++;
      $display("FAIL midreset_stats: flit=%0d packet=%0d stall=%0d, required 1 1 0", flit_cnt, pkt_cnt, stall_cnt);
    end
`endif
    check_drained("reset_mid");
  endtask

  // Random single-flit traffic against a round-robin reference. A source
  // keeps its valid and VC until its flit is taken.
  task automatic test_random();
    int rr_m;
    int w;
    bit hit;
    apply_reset();
    rr_m = 0;
    tail = '1;
    for (int c = 0; c < 300; c++) begin
      for (int s = 0; s < N; s++) begin
        if (!valid[s]) begin
          valid[s] = 1'($urandom_range(0, 1));
          vc_s[s]  = VCW'($urandom_range(0, NVC - 1));
        end
      end
      avail = NVC'($urandom_range(0, 7));
      hit = 1'b0;
      w   = 0;
      for (int i = 0; i < N; i++) begin
        if (!hit && valid[(rr_m + i) % N] && avail[vc_s[(rr_m + i) % N]]) begin
          hit = 1'b1;
          w   = (rr_m + i) % N;
        end
      end
      if (hit) exp_q.push_back({RIW'(w), oh_vc(int'(vc_s[w]))});
      @(negedge clk);
      n_cmp++;
      if (ready !== (hit ? oh_src(w) : 4'b0000)) begin
        n_err++;
        $display("FAIL random_ready[%0d]: got %b, required %b", c, ready, hit ? oh_src(w) : 4'b0000);
      end
      cycle();
      if (hit) begin
        valid[w] = 1'b0;
        rr_m     = (w + 1) % N;
      end
    end
    valid = '0;
    check_drained("random");
  endtask

  initial begin
    rst_n = 1'b0;
    idle_inputs();
    cycle();
    sb_on = 1'b1;
    test_reset();
    test_round_robin();
    test_lock();
    test_avail_stall();
    test_vc_mismatch();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/noc_vc_injection_arbiter.md
Name: noc_vc_injection_arbiter

Overview:
- Shares one NoC injection port among NumberOfRequesters valid/ready flit sources.
- Each source tags its flits with a virtual channel (VC) id.
- The block arbitrates round-robin among sources whose target VC currently has avail asserted, and locks the port to the winner until its tail flit.
- Sits in front of the NoC router input. It drives the router's per-VC valid/avail handshake and the select for an external flit datapath mux.

Parameters:
- NumberOfRequesters, 4, number of upstream flit sources (>=2).
- RequesterIdWidth, 2, width of grant id; must be >= clog2(NumberOfRequesters).
- NumberOfVirtualChannels, 3, number of NoC VCs.
- VirtualChannelIdWidth, 2, width of a VC id; must be >= clog2(NumberOfVirtualChannels).

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  reset, synchronous, active-low.
- valid_i  in  NumberOfRequesters  per-source flit valid.
- ready_o  out  NumberOfRequesters  per-source ready; a flit transfers when valid_i[r] && ready_o[r].
- virtual_channel_id_i  in  NumberOfRequesters*VirtualChannelIdWidth  per-source target VC; source r uses slice r.
- tail_i  in  NumberOfRequesters  per-source "this flit is last of packet".
- grant_id_o  out  RequesterIdWidth  index of the source whose flit is on the datapath this cycle.
- grant_valid_o  out  1  a transfer happens this cycle.
- valid_o  out  NumberOfVirtualChannels  one-hot NoC valid for the VC of the transferred flit.
- avail_i  in  NumberOfVirtualChannels  NoC per-VC availability for this cycle.
- error_o  out  1  sticky protocol error.

Behaviour:
- Reset (rst_ni=0 at a clk_i edge):
  - state=IDLE; rr_ptr=0; owner=0; locked_vc=0; error_o=0.
  - While rst_ni=0, all combinational outputs are forced low: ready_o=0, valid_o=0, grant_valid_o=0, grant_id_o=0.
- Reset mid-packet drops the lock immediately. No flit transfers in the reset cycle.
- Eligibility: source r is eligible when valid_i[r] && avail_i[vc_r], where vc_r is its VC slice. A vc_r >= NumberOfVirtualChannels is never eligible and sets error_o.
- FSM states: IDLE, LOCKED.
- IDLE:
  - Winner = first eligible source scanning rr_ptr, rr_ptr+1, ... with wrap at NumberOfRequesters.
  - Same cycle (zero latency): ready_o[winner]=1, grant_valid_o=1, grant_id_o=winner, valid_o=onehot(vc_winner).
  - If tail_i[winner]=1 (single-flit packet): stay IDLE, rr_ptr <= winner+1 (wrap).
  - Otherwise: go to LOCKED, owner <= winner, locked_vc <= vc_winner.
  - No eligible source: all outputs low, no state change.
- LOCKED:
  - Only the owner is served. ready_o[owner] = avail_i[locked_vc]; all other ready_o bits are 0.
  - A transfer drives valid_o=onehot(locked_vc), grant_id_o=owner, grant_valid_o=1.
  - On a transfer with tail_i[owner]=1: go to IDLE, rr_ptr <= owner+1 (wrap).
  - Owner valid_i low or avail_i[locked_vc] low: hold state, no transfer. Bubbles are allowed; there is no timeout.
  - If the owner presents virtual_channel_id_i != locked_vc while valid_i=1: set error_o. The flit still transfers on locked_vc.
- Output invariants:
  - At most one bit of ready_o and at most one bit of valid_o is high per cycle.
  - valid_o is nonzero iff grant_valid_o=1.
  - grant_id_o holds its last value when grant_valid_o=0, except during reset.
- Combinational paths: avail_i/valid_i -> ready_o/valid_o. No registered output latency.
- Upstream sources must hold valid_i, virtual_channel_id_i and tail_i stable until their transfer (valid/ready rule). The block does not re-check this except for the VC mismatch in LOCKED.
- A source with avail low on its VC never blocks others in IDLE. It is skipped, and rr_ptr does not move.
- error_o is sticky and clears only by reset.

Optional Feature:
- Macro NOC_VC_INJECTION_ARBITER_STATS_EN.
- When defined, add the following outputs, reset to 0, each incrementing on the cycle after the event and saturating at all-ones:
  - flit_count_o (32-bit): +1 per transfer.
  - packet_count_o (32-bit): +1 per tail transfer.
  - stall_count_o (32-bit): +1 per LOCKED cycle in which the owner has valid_i=1 and avail_i[locked_vc]=0.
- When undefined: these ports and counters do not exist, and behaviour is otherwise identical.

Test Plan:
1. Reset: hold rst_ni=0 for 20 cycles with all valid_i=1 and avail_i=3'b111 -> ready_o=0, valid_o=0 and error_o=0 throughout. First transfer after release goes to source 0.
2. Round-robin with single-flit packets: all 4 sources valid, tail=1, VC=0, avail=3'b001 -> grant_id_o sequence 0,1,2,3,0 on consecutive cycles, and valid_o=3'b001 each cycle.
3. Lock: source 1 sends a 4-flit packet on VC 2; source 2 stays valid throughout -> grant_id_o=1 for 4 transfers with valid_o=3'b100, and ready_o[2]=0 until source 1's tail. The next grant goes to source 2.
4. Avail stall/skip: source 0 on VC 0 (avail 0) and source 1 on VC 1 (avail 1) -> source 1 is granted. In LOCKED, deassert avail_i[locked_vc] for 3 cycles -> no transfer; with STATS_EN, stall_count_o=3.
5. VC mismatch: in LOCKED on VC 1, the owner presents VC 2 -> error_o=1 on the next cycle and stays 1; the flit goes out with valid_o=3'b010.
6. Reset mid-packet: assert rst_ni=0 for 1 cycle after the 2nd flit of a 5-flit packet -> state returns to IDLE, rr_ptr=0, and a different valid source can win after release.
